// File: rtl/udp_transmitter.sv
// udp_transmitter: frames a 64-bit payload with source/destination ports into
// a three-word stream (header-0, header-1, data). The checksum is accumulated
// one 16-bit halfword per cycle before the headers are sent.
// Optional build macro: UDP_TX_RFC_CSUM_EN selects a one's-complement
// (end-around carry) checksum instead of the default truncating 16-bit sum.
module udp_transmitter #(
  parameter logic [15:0] LEN_FIELD  = 16'h0040,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [63:0] payload,
  output logic        busy,
  output logic [63:0] out,
  output logic        out_valid,
  output logic        out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_GAP
  } state_e;

  localparam logic [3:0] GAP_W = GAP_CYCLES[3:0];

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [63:0] payload_q, payload_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic [63:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [15:0] halfword;

  // One checksum step: truncating add by default, end-around carry if enabled.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
`ifdef UDP_TX_RFC_CSUM_EN
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[15:0] + {15'd0, sum[16]};
`else
    return a + b;
`endif
  endfunction

  // Select the halfword for this checksum step, most significant first.
  always_comb begin
    unique case (cnt_q)
      2'd0:    halfword = payload_q[63:48];
      2'd1:    halfword = payload_q[47:32];
      2'd2:    halfword = payload_q[31:16];
      default: halfword = payload_q[15:0];
    endcase
  end

  // Next-state and registered-output logic for the framing sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in combinational logic infers a latch.
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    payload_d   = payload_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d     = src_port;
          dst_d     = dst_port;
          payload_d = payload;
          acc_d     = 16'd0;
          cnt_d     = 2'd0;
          state_d   = S_CSUM;
        end
      end
      S_CSUM: begin
        acc_d = csum_add(acc_q, halfword);
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_HDR0;
      end
      S_HDR0: begin
        out_d       = {32'h0, src_q, dst_q};
        out_valid_d = 1'b1;
        state_d     = S_HDR1;
      end
      S_HDR1: begin
        out_d       = {32'h0, LEN_FIELD, ~acc_q};
        out_valid_d = 1'b1;
        state_d     = S_DATA;
      end
      S_DATA: begin
        out_d       = payload_q;
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        if (GAP_W == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d   = GAP_W - 4'd1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      src_q       <= 16'd0;
      dst_q       <= 16'd0;
      payload_q   <= 64'd0;
      acc_q       <= 16'd0;
      cnt_q       <= 2'd0;
      gap_q       <= 4'd0;
      out_q       <= 64'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      payload_q   <= payload_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
